// File: rtl/weight_stream_source.sv
// Weight tile RAM replayed REPS times as a gap-free, backpressure-safe AXI-Stream master.
// Optional build macro WSRC_TLAST_EN adds m_axis_weights_tlast marking the last beat of each block.
module weight_stream_source #(
    parameter int unsigned WEIGHT_WIDTH        = 8,
    parameter int unsigned m_axis_weights_BDIM = 32,
    parameter int unsigned m_axis_weights_SDIM = 4,
    parameter int unsigned REPS_WIDTH          = 16,
    localparam int unsigned DEPTH = m_axis_weights_BDIM * m_axis_weights_SDIM,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [WEIGHT_WIDTH-1:0] cfg_wdata,
    input  logic                    start,
    input  logic [REPS_WIDTH-1:0]   reps,
    output logic                    busy,
    output logic                    done,
    output logic [WEIGHT_WIDTH-1:0] m_axis_weights_tdata,
    output logic                    m_axis_weights_tvalid,
`ifdef WSRC_TLAST_EN
    output logic                    m_axis_weights_tlast,
`endif
    input  logic                    m_axis_weights_tready
);

    localparam int unsigned BW = AW + REPS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FIN    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WEIGHT_WIDTH-1:0] ram [DEPTH];
    logic [WEIGHT_WIDTH-1:0] ram_rdata_c;

    logic [AW-1:0]           rd_addr;
    logic [REPS_WIDTH-1:0]   rd_rep;
    logic                    rd_active;
    logic [REPS_WIDTH-1:0]   reps_q;
    logic [BW-1:0]           beat_cnt;
    logic [BW-1:0]           total_c;

    logic [WEIGHT_WIDTH-1:0] skid_data;
    logic                    skid_vld;

    logic       start_ok_c;
    logic       pop_c;
    logic [1:0] occ_c;
    logic       issue_c;
    logic       rd_wrap_c;
    logic       rd_final_c;
    logic       last_beat_c;
    logic       head_load_c;
    logic       head_take_skid_c;
    logic       head_take_rd_c;
    logic       skid_wr_c;

    // Read-side and handshake control shared by the FSM and the output FIFO.
    always_comb begin
        start_ok_c       = (state == S_IDLE) && start;
        pop_c            = m_axis_weights_tvalid && m_axis_weights_tready;
        occ_c            = {1'b0, m_axis_weights_tvalid} + {1'b0, skid_vld};
        issue_c          = rd_active && ((occ_c < 2'd2) || pop_c);
        rd_wrap_c        = (rd_addr == AW'(DEPTH - 1));
        rd_final_c       = rd_wrap_c && (rd_rep == (reps_q - REPS_WIDTH'(1)));
        total_c          = BW'(reps_q) * BW'(DEPTH);
        last_beat_c      = pop_c && (beat_cnt == (total_c - BW'(1)));
        ram_rdata_c      = ram[rd_addr];
        head_load_c      = !m_axis_weights_tvalid || pop_c;
        head_take_skid_c = head_load_c && skid_vld;
        head_take_rd_c   = head_load_c && !skid_vld && issue_c;
        skid_wr_c        = issue_c && !head_take_rd_c;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (reps != '0) ? S_STREAM : S_FIN;
                end
            end
            S_STREAM: begin
                if (last_beat_c) begin
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs registered from the next state so they line up with the FSM.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_FIN);
        end
    end

    // Tile RAM: writable only while idle; contents survive reset.
    always_ff @(posedge ap_clk) begin
        if (cfg_we && (state == S_IDLE) && (32'(cfg_addr) < DEPTH)) begin
            ram[cfg_addr] <= cfg_wdata;
        end
    end

    // Read address / repetition counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_addr   <= '0;
            rd_rep    <= '0;
            rd_active <= 1'b0;
            reps_q    <= '0;
        end else if (start_ok_c) begin
            rd_addr   <= '0;
            rd_rep    <= '0;
            rd_active <= (reps != '0);
            reps_q    <= reps;
        end else if (issue_c) begin
            if (rd_wrap_c) begin
                rd_addr <= '0;
                rd_rep  <= rd_rep + REPS_WIDTH'(1);
            end else begin
                rd_addr <= rd_addr + AW'(1);
            end
            if (rd_final_c) begin
                rd_active <= 1'b0;
            end
        end
    end

    // Accepted-beat counter; wide enough for DEPTH * (2^REPS_WIDTH - 1).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_cnt <= '0;
        end else if (start_ok_c) begin
            beat_cnt <= '0;
        end else if (pop_c) begin
            beat_cnt <= beat_cnt + BW'(1);
        end
    end

    // Two-entry output FIFO: the output register is the head, skid holds the second beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_axis_weights_tdata  <= '0;
            m_axis_weights_tvalid <= 1'b0;
            skid_data             <= '0;
            skid_vld              <= 1'b0;
        end else begin
            if (head_take_skid_c) begin
                m_axis_weights_tdata  <= skid_data;
                m_axis_weights_tvalid <= 1'b1;
            end else if (head_take_rd_c) begin
                m_axis_weights_tdata  <= ram_rdata_c;
                m_axis_weights_tvalid <= 1'b1;
            end else if (head_load_c) begin
                m_axis_weights_tvalid <= 1'b0;
            end
            if (skid_wr_c) begin
                skid_data <= ram_rdata_c;
            end
            skid_vld <= head_load_c ? (skid_vld && issue_c) : (skid_vld || issue_c);
        end
    end

`ifdef WSRC_TLAST_EN
    logic rd_eob_c;
    logic skid_last;

    assign rd_eob_c = ((32'(rd_addr) % m_axis_weights_BDIM) == (m_axis_weights_BDIM - 1));

    // End-of-block flag travels through the FIFO alongside its data beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_axis_weights_tlast <= 1'b0;
            skid_last            <= 1'b0;
        end else begin
            if (head_take_skid_c) begin
                m_axis_weights_tlast <= skid_last;
            end else if (head_take_rd_c) begin
                m_axis_weights_tlast <= rd_eob_c;
            end else if (head_load_c) begin
                m_axis_weights_tlast <= 1'b0;
            end
            if (skid_wr_c) begin
                skid_last <= rd_eob_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_weight_stream_source.sv
// Directed bench for weight_stream_source: replay order, timing, backpressure, busy-time drops, reset.
// Build with WSRC_TLAST_EN defined to also check m_axis_weights_tlast.
module tb_weight_stream_source;

    localparam int DEPTH = 128;
    localparam int BDIM  = 32;

    logic       ap_clk;
    logic       ap_rst_n;
    logic       cfg_we;
    logic [6:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       start;
    logic [15:0] reps;
    logic       busy;
    logic       done;
    logic [7:0] m_axis_weights_tdata;
    logic       m_axis_weights_tvalid;
    logic       m_axis_weights_tready;
`ifdef WSRC_TLAST_EN
    logic       m_axis_weights_tlast;
`endif

    weight_stream_source dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .cfg_we                (cfg_we),
        .cfg_addr              (cfg_addr),
        .cfg_wdata             (cfg_wdata),
        .start                 (start),
        .reps                  (reps),
        .busy                  (busy),
        .done                  (done),
        .m_axis_weights_tdata  (m_axis_weights_tdata),
        .m_axis_weights_tvalid (m_axis_weights_tvalid),
`ifdef WSRC_TLAST_EN
        .m_axis_weights_tlast  (m_axis_weights_tlast),
`endif
        .m_axis_weights_tready (m_axis_weights_tready)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem_model [DEPTH];
    int         beat_n    = 0;
    int         beat_base = 0;
    logic       stall_q   = 1'b0;
    logic [7:0] stall_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stream monitor: checks every accepted beat against the model and AXI-Stream hold rules.
    always @(negedge ap_clk) begin
        int idx;
        if (!ap_rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_tvalid", 32'(m_axis_weights_tvalid), 32'd1);
                check("hold_tdata", 32'(m_axis_weights_tdata), 32'(stall_data));
            end
            if (m_axis_weights_tvalid && m_axis_weights_tready) begin
                idx = (beat_n - beat_base) % DEPTH;
                check("beat_data", 32'(m_axis_weights_tdata), 32'(mem_model[idx]));
`ifdef WSRC_TLAST_EN
                check("beat_tlast", 32'(m_axis_weights_tlast), 32'((idx % BDIM) == (BDIM - 1)));
`endif
                beat_n++;
            end
            stall_q    = m_axis_weights_tvalid && !m_axis_weights_tready;
            stall_data = m_axis_weights_tdata;
        end
    end

    task automatic write_word(input int addr, input logic [7:0] data);
        @(posedge ap_clk); #1;
        cfg_we    = 1'b1;
        cfg_addr  = 7'(addr);
        cfg_wdata = data;
        mem_model[addr] = data;
        @(posedge ap_clk); #1;
        cfg_we = 1'b0;
    endtask

    // Start one replay and follow it to done; inj>0 fires a stray write+start at that cycle.
    task automatic run_stream(input int r, input bit rnd, input int inj, input string tag);
        int total;
        int exp_done;
        int cyc;
        bit seen;
        total    = r * DEPTH;
        exp_done = (r == 0) ? 1 : total + 2;
        seen     = 1'b0;
        cyc      = 0;
        @(posedge ap_clk); #1;
        start = 1'b1;
        reps  = 16'(r);
        m_axis_weights_tready = 1'b1;
        beat_base = beat_n;
        while (!seen && cyc < 20 * total + 40) begin
            @(posedge ap_clk); #1;
            cyc++;
            start  = 1'b0;
            cfg_we = 1'b0;
            if (cyc == inj) begin
                cfg_we    = 1'b1;
                cfg_addr  = 7'd5;
                cfg_wdata = 8'hEE;
                start     = 1'b1;
                reps      = 16'd2;
            end
            if (cyc == 1) begin
                check({tag, "_busy_c1"}, 32'(busy), 32'd1);
                check({tag, "_tvalid_c1"}, 32'(m_axis_weights_tvalid), 32'd0);
            end
            if (cyc == 2 && r != 0 && !rnd) begin
                check({tag, "_tvalid_c2"}, 32'(m_axis_weights_tvalid), 32'd1);
                check({tag, "_tdata_c2"}, 32'(m_axis_weights_tdata), 32'(mem_model[0]));
            end
            if (done) begin
                seen = 1'b1;
                if (!rnd) check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
                check({tag, "_tvalid_at_done"}, 32'(m_axis_weights_tvalid), 32'd0);
                check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
                check({tag, "_beats"}, 32'(beat_n - beat_base), 32'(total));
            end
            m_axis_weights_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
        end
        @(posedge ap_clk); #1;
        m_axis_weights_tready = 1'b1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_beats_after"}, 32'(beat_n - beat_base), 32'(total));
    endtask

    // Reset in the middle of a tile after 40 accepted beats.
    task automatic reset_mid_stream();
        @(posedge ap_clk); #1;
        start = 1'b1;
        reps  = 16'd1;
        m_axis_weights_tready = 1'b1;
        beat_base = beat_n;
        @(posedge ap_clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400 && (beat_n - beat_base) < 40; c++) begin
            @(posedge ap_clk); #1;
        end
        check("rst_beats_before", 32'(beat_n - beat_base), 32'd40);
        check("rst_tvalid_before", 32'(m_axis_weights_tvalid), 32'd1);
        ap_rst_n = 1'b0;
        #1;
        check("rst_tvalid", 32'(m_axis_weights_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tdata", 32'(m_axis_weights_tdata), 32'd0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("rst_busy_release", 32'(busy), 32'd0);
        check("rst_done_release", 32'(done), 32'd0);
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        start     = 1'b0;
        reps      = '0;
        m_axis_weights_tready = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tvalid", 32'(m_axis_weights_tvalid), 32'd0);
        check("reset_tdata", 32'(m_axis_weights_tdata), 32'd0);
`ifdef WSRC_TLAST_EN
        check("reset_tlast", 32'(m_axis_weights_tlast), 32'd0);
`endif
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            write_word(i, 8'(i));
        end

        run_stream(1, 1'b0, -1, "r1");
        run_stream(3, 1'b0, -1, "r3");
        run_stream(2, 1'b1, -1, "rnd");
        run_stream(0, 1'b0, -1, "r0");
        run_stream(1, 1'b0, 10, "ign");

        write_word(5, 8'hA5);
        reset_mid_stream();
        run_stream(1, 1'b0, -1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
